nf10_upb_reset_sequencer: RTL and testbench



---
 rtl/nf10_upb_reset_sequencer.sv | 173 +++++++++++++++++
 tb/tb_nf10_upb_reset_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_upb_reset_sequencer.sv
// Reset sequencer: synchronises lock/ready flags, waits for them to be stable, then releases
// reset domains one at a time in ascending order. Any lock loss re-asserts every domain.
module nf10_upb_reset_sequencer #(
    parameter int unsigned              NUM_LOCKS     = 2,
    parameter logic [NUM_LOCKS-1:0]     LOCK_MASK     = '1,
    parameter int unsigned              NUM_DOMAINS   = 3,
    parameter int unsigned              HOLD_CYCLES   = 16,
    parameter int unsigned              STABLE_CYCLES = 32,
    parameter int unsigned              STAGE_DELAY   = 8,
    parameter int unsigned              LOCK_TIMEOUT  = 1024,
    parameter int unsigned              CNT_W         = 8
) (
    input  logic                   clk_in,
    input  logic                   async_reset_in_n,
    input  logic [NUM_LOCKS-1:0]   locked_in,
    output logic [NUM_DOMAINS-1:0] reset_out,
    output logic [NUM_DOMAINS-1:0] reset_n_out,
    output logic                   all_released_out,
    output logic [2:0]             state_out,
    output logic                   timeout_out,
    output logic [CNT_W-1:0]       lock_lost_count_out
);

    localparam int unsigned MAX_HS  = (HOLD_CYCLES > STABLE_CYCLES) ? HOLD_CYCLES : STABLE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_HS > STAGE_DELAY) ? MAX_HS : STAGE_DELAY;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    localparam int unsigned TW      = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        StHold      = 3'd0,
        StWaitLock  = 3'd1,
        StStabilize = 3'd2,
        StRelease   = 3'd3,
        StRun       = 3'd4
    } state_e;

    logic [NUM_LOCKS-1:0]   sync1_q, sync2_q;
    logic                   locks_ok;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d;
    logic [NUM_DOMAINS-1:0] rst_n_q;
    logic                   all_rel_q, all_rel_d;
    logic                   timeout_q, timeout_d;
    logic [CNT_W-1:0]       lost_q, lost_d;

    always_ff @(posedge clk_in or negedge async_reset_in_n) begin
        if (!async_reset_in_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= locked_in;
            sync2_q <= sync1_q;
        end
    end

    // Masked-off inputs count as locked.
    assign locks_ok = &(sync2_q | ~LOCK_MASK);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        rst_d     = rst_q;
        all_rel_d = all_rel_q;
        timeout_d = timeout_q;
        lost_d    = lost_q;

        if ((state_q == StRelease || state_q == StRun) && !locks_ok) begin
            // Loss beats any release scheduled for this edge.
            state_d   = StHold;
            cnt_d     = '0;
            rst_d     = '1;
            all_rel_d = 1'b0;
            if (lost_q != '1) begin
                lost_d = lost_q + CNT_W'(1);
            end
        end else begin
            case (state_q)
                StHold: begin
                    if (cnt_q == CW'(HOLD_CYCLES)) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StWaitLock: begin
                    if (locks_ok) begin
                        state_d = StStabilize;
                        cnt_d   = '0;
                        tcnt_d  = '0;
                    end else if (LOCK_TIMEOUT != 0 && tcnt_q != TW'(LOCK_TIMEOUT)) begin
                        tcnt_d = tcnt_q + TW'(1);
                        if (tcnt_q == TW'(LOCK_TIMEOUT - 1)) begin
                            timeout_d = 1'b1;
                        end
                    end
                end
                StStabilize: begin
                    if (!locks_ok) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                        cnt_d   = '0;
                        rst_d   = rst_q << 1;
                        state_d = StRelease;
                        if (rst_d == '0) begin
                            state_d   = StRun;
                            all_rel_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StRelease: begin
                    // Released domains are the low zeros of rst_q; shifting keeps release in order.
                    if (cnt_q == CW'(STAGE_DELAY - 1)) begin
                        cnt_d = '0;
                        rst_d = rst_q << 1;
                        if (rst_d == '0) begin
                            state_d   = StRun;
                            all_rel_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StRun: begin
                    state_d = StRun;
                end
                default: begin
                    state_d   = StHold;
                    cnt_d     = '0;
                    rst_d     = '1;
                    all_rel_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge async_reset_in_n) begin
        if (!async_reset_in_n) begin
            state_q   <= StHold;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            rst_q     <= '1;
            rst_n_q   <= '0;
            all_rel_q <= 1'b0;
            timeout_q <= 1'b0;
            lost_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            rst_q     <= rst_d;
            rst_n_q   <= ~rst_d;
            all_rel_q <= all_rel_d;
            timeout_q <= timeout_d;
            lost_q    <= lost_d;
        end
    end

    assign reset_out           = rst_q;
    assign reset_n_out         = rst_n_q;
    assign all_released_out    = all_rel_q;
    assign state_out           = state_q;
    assign timeout_out         = timeout_q;
    assign lock_lost_count_out = lost_q;

endmodule

// File: tb/tb_nf10_upb_reset_sequencer.sv
// Bench for nf10_upb_reset_sequencer: directed scenarios plus random lock glitches, checked
// against a phase/age reference model for a default instance and a masked, narrow-counter one.
module tb_nf10_upb_reset_sequencer;

    localparam int ND     = 3;
    localparam int HOLD   = 16;
    localparam int STABLE = 32;
    localparam int STAGE  = 8;
    localparam int TMO    = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] locked = 2'b11;

    logic [2:0] rst_a, rstn_a, st_a;
    logic       allr_a, tmo_a;
    logic [7:0] cnt_a;
    logic [2:0] rst_b, rstn_b, st_b;
    logic       allr_b, tmo_b;
    logic [1:0] cnt_b;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n = -1;

    always #5 clk = ~clk;

    nf10_upb_reset_sequencer dut_a (
        .clk_in              (clk),
        .async_reset_in_n    (rst_n),
        .locked_in           (locked),
        .reset_out           (rst_a),
        .reset_n_out         (rstn_a),
        .all_released_out    (allr_a),
        .state_out           (st_a),
        .timeout_out         (tmo_a),
        .lock_lost_count_out (cnt_a)
    );

    nf10_upb_reset_sequencer #(
        .LOCK_MASK (2'b01),
        .CNT_W     (2)
    ) dut_b (
        .clk_in              (clk),
        .async_reset_in_n    (rst_n),
        .locked_in           (locked),
        .reset_out           (rst_b),
        .reset_n_out         (rstn_b),
        .all_released_out    (allr_b),
        .state_out           (st_b),
        .timeout_out         (tmo_b),
        .lock_lost_count_out (cnt_b)
    );

    // Reference model, index 0 = dut_a, 1 = dut_b. Phase uses the state_out numbering.
    int m_phase[2], m_age[2], m_rel[2], m_lost[2];
    bit m_tmo[2], m_p1[2], m_p2[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic bit ok_of(int i, logic [1:0] lk);
        return (i == 0) ? (lk == 2'b11) : lk[0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_age[i] = 0; m_rel[i] = 0; m_lost[i] = 0;
            m_tmo[i] = 0; m_p1[i] = 0; m_p2[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [1:0] lk);
        for (int i = 0; i < 2; i++) begin
            bit ok;
            int lmax;
            ok = m_p2[i];
            m_p2[i] = m_p1[i];
            m_p1[i] = ok_of(i, lk);
            lmax = (i == 0) ? 255 : 3;
            case (m_phase[i])
                0: begin
                    m_age[i]++;
                    if (m_age[i] > HOLD) begin m_phase[i] = 1; m_age[i] = 0; end
                end
                1: begin
                    if (ok) begin
                        m_phase[i] = 2; m_age[i] = 0;
                    end else begin
                        m_age[i]++;
                        if (m_age[i] == TMO) m_tmo[i] = 1;
                    end
                end
                2: begin
                    if (!ok) begin
                        m_phase[i] = 1; m_age[i] = 0;
                    end else begin
                        m_age[i]++;
                        if (m_age[i] == STABLE) begin
                            m_rel[i] = 1; m_age[i] = 0;
                            m_phase[i] = (ND == 1) ? 4 : 3;
                        end
                    end
                end
                default: begin
                    if (!ok) begin
                        m_rel[i] = 0; m_phase[i] = 0; m_age[i] = 0;
                        if (m_lost[i] < lmax) m_lost[i]++;
                    end else if (m_phase[i] == 3) begin
                        m_age[i]++;
                        if (m_age[i] == STAGE) begin
                            m_rel[i]++; m_age[i] = 0;
                            if (m_rel[i] == ND) m_phase[i] = 4;
                        end
                    end
                end
            endcase
        end
    endtask

    function automatic logic [31:0] exp_vec(int i);
        logic [2:0] r;
        logic [2:0] ph;
        logic [7:0] lc;
        for (int d = 0; d < ND; d++) r[d] = (d >= m_rel[i]);
        ph = 3'(m_phase[i]);
        lc = 8'(m_lost[i]);
        return {13'd0, ph, r, ~r, (m_phase[i] == 4), m_tmo[i], lc};
    endfunction

    task automatic check_outputs();
        check_eq("outputs_a", {13'd0, st_a, rst_a, rstn_a, allr_a, tmo_a, cnt_a}, exp_vec(0));
        check_eq("outputs_b", {13'd0, st_b, rst_b, rstn_b, allr_b, tmo_b, 6'd0, cnt_b}, exp_vec(1));
    endtask

    // Call at a negedge; asserts reset, checks values before any clock edge, then releases.
    task automatic do_reset(input logic [1:0] lk);
        locked = lk;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("reset_out_rst", rst_a, 3'b111);
        check_eq("reset_n_out_rst", rstn_a, 3'b000);
        check_eq("state_rst", st_a, 3'd0);
        check_eq("released_tmo_cnt_rst", {allr_a, tmo_a, cnt_a, cnt_b}, 12'd0);
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        edge_n = -1;
    endtask

    task automatic tick(input logic [1:0] lk);
        locked = lk;
        @(posedge clk);
        edge_n++;
        model_edge(lk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic plan_check();
        case (edge_n)
            15: check_eq("hold_at_15", st_a, 3'd0);
            16: check_eq("wait_at_16", st_a, 3'd1);
            17: check_eq("stab_at_17", st_a, 3'd2);
            48: check_eq("rst_at_48", rst_a, 3'b111);
            49: check_eq("rst_at_49", rst_a, 3'b110);
            56: check_eq("rst_at_56", rst_a, 3'b110);
            57: check_eq("rst_at_57", rst_a, 3'b100);
            64: check_eq("rst_at_64", {allr_a, rst_a}, 4'b0100);
            65: check_eq("run_at_65", {allr_a, rst_a, cnt_a}, {4'b1000, 8'd0});
            default: ;
        endcase
    endtask

    initial begin
        #2;
        // Nominal power-up timing.
        do_reset(2'b11);
        repeat (70) begin
            tick(2'b11);
            plan_check();
        end

        // Lock wait timeout; masked dut_b completes regardless.
        do_reset(2'b01);
        while (edge_n < 1039) tick(2'b01);
        check_eq("tmo_before", tmo_a, 1'b0);
        tick(2'b01);
        check_eq("tmo_set", {tmo_a, rst_a}, 4'b1111);
        repeat (60) tick(2'b01);
        check_eq("tmo_held", {tmo_a, rst_a, st_a}, {4'b1111, 3'd1});
        repeat (80) tick(2'b11);
        check_eq("after_tmo_run", {allr_a, tmo_a}, 2'b11);

        // One-cycle loss in RUN.
        tick(2'b01);
        tick(2'b11);
        check_eq("loss_not_yet", rst_a, 3'b000);
        tick(2'b11);
        check_eq("loss_seen", {rst_a, st_a, cnt_a}, {3'b111, 3'd0, 8'd1});
        repeat (80) tick(2'b11);
        check_eq("rerun", {allr_a, cnt_a}, {1'b1, 8'd1});

        // Glitch during STABILIZE restarts the stability window.
        do_reset(2'b11);
        while (edge_n < 37) tick(2'b11);
        tick(2'b10);
        while (edge_n < 40) tick(2'b11);
        check_eq("stab_glitch_wait", st_a, 3'd1);
        while (edge_n < 72) tick(2'b11);
        check_eq("stab_restart_72", rst_a, 3'b111);
        tick(2'b11);
        check_eq("stab_restart_73", {rst_a, cnt_a}, {3'b110, 8'd0});

        // Loss on the edge that would release domain 1.
        do_reset(2'b11);
        while (edge_n < 57) tick((edge_n == 54) ? 2'b00 : 2'b11);
        check_eq("loss_vs_release", {rst_a, cnt_a}, {3'b111, 8'd1});
        repeat (5) tick(2'b11);
        check_eq("loss_stays", rst_a, 3'b111);

        // Five losses in RUN: dut_b counter saturates at 3.
        repeat (5) begin
            repeat (75) tick(2'b11);
            tick(2'b00);
        end
        repeat (3) tick(2'b11);
        check_eq("sat_b", cnt_b, 2'd3);
        check_eq("count_a", cnt_a, 8'd6);

        // Async reset during RELEASE, then masked bit1 tied low.
        do_reset(2'b11);
        while (edge_n < 52) tick(2'b11);
        check_eq("mid_release", rst_a, 3'b110);
        do_reset(2'b01);
        repeat (70) tick(2'b01);
        check_eq("mask_done", {allr_b, rst_b, allr_a}, 5'b10000);

        // Random lock glitches with occasional async resets.
        repeat (3000) begin
            if ($urandom_range(0, 599) == 0) do_reset(2'($urandom));
            tick(($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b11);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
